// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the pipelined MIPS core. It keeps a
// registered scoreboard of in-flight writers, one entry per stage after
// decode (entry 1 = E, entry 2 = M, ...). Each entry holds a destination
// register and a remaining-latency count (tnew). A separate counter tracks
// how busy the multiply/divide unit is.
//
// From that state and the current decode-stage (D) inputs, the block
// combinationally produces:
//    - the D-stage stall, and
//    - the operand forwarding selects for the D and E stages.
//
// Ports
//    clk, reset             clock, synchronous active-high reset
//    d_valid                D holds a real instruction
//    d_rs, d_rt             D source registers
//    d_use_rs, d_use_rt     source is actually read
//    d_tuse_rs, d_tuse_rt   cycles after D until the source value is needed
//    d_dst, d_tnew          destination (0 = none) and its result latency
//    d_md, d_md_start       HI/LO user / multiply-divide start
//    d_md_div               the start is a divide
//    flush                  clears E..W to bubbles at the next edge
//    stall                  freeze PC and IF/ID, and insert a bubble into E
//    md_busy                multiply/divide counter nonzero
//    fwd_d_rs, fwd_d_rt     D operand source (0 = regfile, k = stage k)
//    fwd_e_rs, fwd_e_rt     E operand source (0 = latched, k = stage k >= 2)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NREG_W  = 5,
   parameter int STAGES  = 3,
   parameter int TNEW_W  = 2,
   parameter int SEL_W   = 3,
   parameter int CNT_W   = 4,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [NREG_W-1:0] d_rs,
   input  logic [NREG_W-1:0] d_rt,
   input  logic              d_use_rs,
   input  logic              d_use_rt,
   input  logic [TNEW_W-1:0] d_tuse_rs,
   input  logic [TNEW_W-1:0] d_tuse_rt,
   input  logic [NREG_W-1:0] d_dst,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic              d_md,
   input  logic              d_md_start,
   input  logic              d_md_div,
   input  logic              flush,
   output logic              stall,
   output logic              md_busy,
   output logic [SEL_W-1:0]  fwd_d_rs,
   output logic [SEL_W-1:0]  fwd_d_rt,
   output logic [SEL_W-1:0]  fwd_e_rs,
   output logic [SEL_W-1:0]  fwd_e_rt
);

   typedef logic [NREG_W-1:0] dst_arr_t  [1:STAGES];
   typedef logic [TNEW_W-1:0] tnew_arr_t [1:STAGES];

   // Lowest entry index k >= first whose destination equals src; 0 if none.
   // The scan runs from the oldest entry to the youngest, so the youngest
   // matching writer is the one that survives.
   function automatic logic [SEL_W-1:0] youngest_match(
      input logic [NREG_W-1:0] src,
      input logic              use_src,
      input int                first,
      input dst_arr_t          dsts
   );
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int k = STAGES; k >= 1; k--) begin
         idx = (use_src && (src != {NREG_W{1'b0}}) && (k >= first) && (dsts[k] == src))
               ? SEL_W'(k) : idx;
      end
      return idx;
   endfunction

   // tnew of entry idx. idx = 0 (no match) returns 0.
   function automatic logic [TNEW_W-1:0] tnew_at(
      input logic [SEL_W-1:0] idx,
      input tnew_arr_t        tnews
   );
      logic [TNEW_W-1:0] t;
      t = {TNEW_W{1'b0}};
      for (int k = 1; k <= STAGES; k++) begin
         t = (idx == SEL_W'(k)) ? tnews[k] : t;
      end
      return t;
   endfunction

   // Ageing step: one cycle closer to forwardable, saturating at 0.
   function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
      return (t == {TNEW_W{1'b0}}) ? {TNEW_W{1'b0}} : (t - TNEW_W'(1));
   endfunction

   // Scoreboard state
   dst_arr_t          dst_q, dst_d;
   tnew_arr_t         tnew_q, tnew_d;
   logic [NREG_W-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic              e_use_rs_q, e_use_rs_d, e_use_rt_q, e_use_rt_d;
   logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;

   // Lookup results and hazard terms
   logic [SEL_W-1:0]  d_rs_idx_s, d_rt_idx_s, e_rs_idx_s, e_rt_idx_s;
   logic [TNEW_W-1:0] d_rs_tnew_s, d_rt_tnew_s, e_rs_tnew_s, e_rt_tnew_s;
   logic              rs_haz_s, rt_haz_s, md_haz_s, md_busy_s, stall_s;
   logic              issue_s;

   // Youngest-writer lookups and the D-stage stall decision
   always_comb begin
      d_rs_idx_s  = youngest_match(d_rs, d_use_rs, 1, dst_q);
      d_rt_idx_s  = youngest_match(d_rt, d_use_rt, 1, dst_q);
      e_rs_idx_s  = youngest_match(e_rs_q, e_use_rs_q, 2, dst_q);
      e_rt_idx_s  = youngest_match(e_rt_q, e_use_rt_q, 2, dst_q);
      d_rs_tnew_s = tnew_at(d_rs_idx_s, tnew_q);
      d_rt_tnew_s = tnew_at(d_rt_idx_s, tnew_q);
      e_rs_tnew_s = tnew_at(e_rs_idx_s, tnew_q);
      e_rt_tnew_s = tnew_at(e_rt_idx_s, tnew_q);
      // A producer is a hazard only if it cannot be ready by the use time.
      rs_haz_s    = (d_rs_idx_s != {SEL_W{1'b0}}) && (d_rs_tnew_s > d_tuse_rs);
      rt_haz_s    = (d_rt_idx_s != {SEL_W{1'b0}}) && (d_rt_tnew_s > d_tuse_rt);
      md_busy_s   = (md_cnt_q != {CNT_W{1'b0}});
      md_haz_s    = d_md && md_busy_s;
      stall_s     = d_valid && (rs_haz_s || rt_haz_s || md_haz_s);
   end

   // Output drive: forward only from an entry whose result is already available
   always_comb begin
      stall    = stall_s;
      md_busy  = md_busy_s;
      fwd_d_rs = ((d_rs_idx_s != {SEL_W{1'b0}}) && (d_rs_tnew_s == {TNEW_W{1'b0}}))
                 ? d_rs_idx_s : {SEL_W{1'b0}};
      fwd_d_rt = ((d_rt_idx_s != {SEL_W{1'b0}}) && (d_rt_tnew_s == {TNEW_W{1'b0}}))
                 ? d_rt_idx_s : {SEL_W{1'b0}};
      fwd_e_rs = ((e_rs_idx_s != {SEL_W{1'b0}}) && (e_rs_tnew_s == {TNEW_W{1'b0}}))
                 ? e_rs_idx_s : {SEL_W{1'b0}};
      fwd_e_rt = ((e_rt_idx_s != {SEL_W{1'b0}}) && (e_rt_tnew_s == {TNEW_W{1'b0}}))
                 ? e_rt_idx_s : {SEL_W{1'b0}};
   end

   // Next-state: shift and age the scoreboard, load entry 1, run the md counter
   always_comb begin
      // flush has priority over loading D into entry 1
      issue_s    = d_valid && !stall_s && !flush;

      dst_d[1]   = issue_s ? d_dst  : {NREG_W{1'b0}};
      tnew_d[1]  = issue_s ? d_tnew : {TNEW_W{1'b0}};
      e_rs_d     = issue_s ? d_rs   : {NREG_W{1'b0}};
      e_rt_d     = issue_s ? d_rt   : {NREG_W{1'b0}};
      e_use_rs_d = issue_s && d_use_rs;
      e_use_rt_d = issue_s && d_use_rt;

      for (int k = 2; k <= STAGES; k++) begin
         dst_d[k]  = flush ? {NREG_W{1'b0}} : dst_q[k-1];
         tnew_d[k] = flush ? {TNEW_W{1'b0}} : dec_sat(tnew_q[k-1]);
      end

      // flush leaves the counter alone: an operation already started completes
      if (d_valid && d_md_start && !stall_s) begin
         md_cnt_d = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (md_cnt_q != {CNT_W{1'b0}}) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end else begin
         md_cnt_d = {CNT_W{1'b0}};
      end
   end

   // State registers with synchronous reset to an all-bubble scoreboard
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= STAGES; k++) begin
            dst_q[k]  <= {NREG_W{1'b0}};
            tnew_q[k] <= {TNEW_W{1'b0}};
         end
         e_rs_q     <= {NREG_W{1'b0}};
         e_rt_q     <= {NREG_W{1'b0}};
         e_use_rs_q <= 1'b0;
         e_use_rt_q <= 1'b0;
         md_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         dst_q      <= dst_d;
         tnew_q     <= tnew_d;
         e_rs_q     <= e_rs_d;
         e_rt_q     <= e_rt_d;
         e_use_rs_q <= e_use_rs_d;
         e_use_rt_q <= e_use_rt_d;
         md_cnt_q   <= md_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. The main instance uses the default
// parameters and is checked every cycle against a model. The model keeps a
// history of issued instructions indexed by issue cycle: the instruction in
// stage k at cycle n is the one issued at cycle n-k, with tnew reduced by
// (k-1). A second instance (STAGES=5, TNEW_W=3) is checked with
// hand-computed literal values only.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int MS  = 3;   // main instance depth
   localparam int MUL = 5;
   localparam int DIV = 10;

   logic       clk;
   logic       reset;
   logic       d_valid, d_use_rs, d_use_rt, d_md, d_md_start, d_md_div, flush;
   logic [4:0] d_rs, d_rt, d_dst;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       stall, md_busy;
   logic [2:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

   logic       p_d_valid, p_d_use_rs, p_d_use_rt, p_d_md, p_d_md_start, p_d_md_div, p_flush;
   logic [4:0] p_d_rs, p_d_rt, p_d_dst;
   logic [2:0] p_d_tuse_rs, p_d_tuse_rt, p_d_tnew;
   logic       p_stall, p_md_busy;
   logic [2:0] p_fwd_d_rs, p_fwd_d_rt, p_fwd_e_rs, p_fwd_e_rt;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_dst(d_dst), .d_tnew(d_tnew), .d_md(d_md), .d_md_start(d_md_start),
      .d_md_div(d_md_div), .flush(flush), .stall(stall), .md_busy(md_busy),
      .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
   );

   hazard_scoreboard #(.STAGES(5), .TNEW_W(3), .SEL_W(3)) dut5 (
      .clk(clk), .reset(reset), .d_valid(p_d_valid), .d_rs(p_d_rs), .d_rt(p_d_rt),
      .d_use_rs(p_d_use_rs), .d_use_rt(p_d_use_rt), .d_tuse_rs(p_d_tuse_rs),
      .d_tuse_rt(p_d_tuse_rt), .d_dst(p_d_dst), .d_tnew(p_d_tnew), .d_md(p_d_md),
      .d_md_start(p_d_md_start), .d_md_div(p_d_md_div), .flush(p_flush),
      .stall(p_stall), .md_busy(p_md_busy), .fwd_d_rs(p_fwd_d_rs), .fwd_d_rt(p_fwd_d_rt),
      .fwd_e_rs(p_fwd_e_rs), .fwd_e_rt(p_fwd_e_rt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- model state ----------------
   int cyc     = 0;
   int horizon = 0;    // issues at cycles below this are dead (reset/flush)
   int md_end  = -1;   // md unit busy while cyc <= md_end
   bit exp_stall_q = 1'b0;
   bit h_valid [0:4095];
   int h_dst   [0:4095];
   int h_tnew  [0:4095];
   int h_rs    [0:4095];
   int h_rt    [0:4095];
   bit h_urs   [0:4095];
   bit h_urt   [0:4095];

   function automatic bit alive(input int c);
      return (c >= 0) && (c >= horizon) && h_valid[c];
   endfunction

   // Youngest writer of s among stages first..MS; returns stage and remaining latency
   function automatic void lookup(input int s, input bit u, input int first,
                                  output int k_o, output int rem_o);
      k_o = 0;
      rem_o = 0;
      if (u && s != 0) begin
         for (int k = first; k <= MS; k++) begin
            if (k_o == 0 && alive(cyc - k) && h_dst[cyc - k] == s) begin
               k_o   = k;
               rem_o = h_tnew[cyc - k] - (k - 1);
               if (rem_o < 0) rem_o = 0;
            end
         end
      end
   endfunction

   // Compare process: model expectation vs DUT on every non-reset cycle
   initial begin
      int k_rs, r_rs, k_rt, r_rt, k_ers, r_ers, k_ert, r_ert;
      int e_rs, e_rt;
      bit e_urs, e_urt, m_stall, m_busy;
      forever begin
         @(negedge clk);
         if (reset) begin
            horizon     = cyc + 1;
            md_end      = cyc;
            exp_stall_q = 1'b0;
         end else begin
            lookup(int'(d_rs), d_use_rs, 1, k_rs, r_rs);
            lookup(int'(d_rt), d_use_rt, 1, k_rt, r_rt);
            m_busy  = (cyc <= md_end);
            m_stall = d_valid && ((k_rs != 0 && r_rs > int'(d_tuse_rs)) ||
                                  (k_rt != 0 && r_rt > int'(d_tuse_rt)) ||
                                  (d_md && m_busy));
            if (alive(cyc - 1)) begin
               e_rs = h_rs[cyc - 1];  e_urs = h_urs[cyc - 1];
               e_rt = h_rt[cyc - 1];  e_urt = h_urt[cyc - 1];
            end else begin
               e_rs = 0; e_urs = 1'b0; e_rt = 0; e_urt = 1'b0;
            end
            lookup(e_rs, e_urs, 2, k_ers, r_ers);
            lookup(e_rt, e_urt, 2, k_ert, r_ert);

            chk("stall",    stall,    m_stall);
            chk("md_busy",  md_busy,  m_busy);
            chk("fwd_d_rs", fwd_d_rs, (k_rs  != 0 && r_rs  == 0) ? k_rs  : 0);
            chk("fwd_d_rt", fwd_d_rt, (k_rt  != 0 && r_rt  == 0) ? k_rt  : 0);
            chk("fwd_e_rs", fwd_e_rs, (k_ers != 0 && r_ers == 0) ? k_ers : 0);
            chk("fwd_e_rt", fwd_e_rt, (k_ert != 0 && r_ert == 0) ? k_ert : 0);

            exp_stall_q = m_stall;
            if (flush) begin
               horizon = cyc + 1;
            end else begin
               h_valid[cyc] = d_valid && !m_stall;
               h_dst[cyc]   = int'(d_dst);
               h_tnew[cyc]  = int'(d_tnew);
               h_rs[cyc]    = int'(d_rs);
               h_rt[cyc]    = int'(d_rt);
               h_urs[cyc]   = d_use_rs;
               h_urt[cyc]   = d_use_rt;
            end
            if (d_valid && d_md_start && !m_stall) md_end = cyc + (d_md_div ? DIV : MUL);
         end
         cyc = cyc + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input int rs, input bit urs, input int trs,
                        input int rt, input bit urt, input int trt,
                        input int dst, input int tn, input bit md, input bit mds, input bit mdiv);
      d_valid = v;        d_rs = rs[4:0];  d_use_rs = urs; d_tuse_rs = trs[1:0];
      d_rt = rt[4:0];     d_use_rt = urt;  d_tuse_rt = trt[1:0];
      d_dst = dst[4:0];   d_tnew = tn[1:0];
      d_md = md;          d_md_start = mds; d_md_div = mdiv;
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic p_drive(input bit v, input int rs, input bit urs, input int trs,
                          input int dst, input int tn);
      p_d_valid = v;      p_d_rs = rs[4:0]; p_d_use_rs = urs; p_d_tuse_rs = trs[2:0];
      p_d_rt = 5'd0;      p_d_use_rt = 1'b0; p_d_tuse_rt = 3'd0;
      p_d_dst = dst[4:0]; p_d_tnew = tn[2:0];
      p_d_md = 1'b0;      p_d_md_start = 1'b0; p_d_md_div = 1'b0; p_flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present one instruction and hold it until the model says it has issued
   task automatic send(input int rs, input bit urs, input int trs,
                       input int rt, input bit urt, input int trt,
                       input int dst, input int tn, input bit md, input bit mds, input bit mdiv);
      int n;
      drive(1'b1, rs, urs, trs, rt, urt, trt, dst, tn, md, mds, mdiv);
      n = 0;
      do begin
         tick();
         n++;
      end while (exp_stall_q && n < 40);
      chk("issue_bound", (n < 40), 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      flush = 1'b0;
      idle();
      p_drive(1'b0, 0, 1'b0, 0, 0, 0);
      repeat (3) tick();
      reset = 1'b0;
      settle();
      chk("rst_stall",    stall,    0);
      chk("rst_md_busy",  md_busy,  0);
      chk("rst_fwd_d_rs", fwd_d_rs, 0);
      chk("rst_fwd_e_rt", fwd_e_rt, 0);

      // load-use: lw $5 (tnew 2) then addu reading $5 at tuse 1
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 5, 2, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b1, 5, 1'b1, 1, 0, 1'b0, 0, 6, 1, 1'b0, 1'b0, 1'b0);
      settle(); chk("lu_stall", stall, 1);
      tick(); settle();
      chk("lu_release", stall, 0);
      chk("lu_fwd_d",   fwd_d_rs, 0);
      tick(); idle(); settle();
      chk("lu_fwd_e", fwd_e_rs, 3);

      // youngest wins: two writers of $8, then a reader at tuse 0
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 8, 1, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 8, 0, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b1, 8, 1'b1, 0, 0, 1'b0, 0, 9, 0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("yw_stall", stall, 0);
      chk("yw_fwd_d", fwd_d_rs, 1);
      tick(); idle(); settle();
      chk("yw_fwd_e", fwd_e_rs, 2);

      // $0 is never a hazard; an unused matching source is ignored
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b1, 0, 1'b1, 0, 0, 1'b0, 0, 11, 0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("r0_stall", stall, 0);
      chk("r0_fwd_d", fwd_d_rs, 0);
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 9, 2, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b1, 0, 1'b0, 0, 9, 1'b0, 0, 12, 0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("nouse_stall", stall, 0);
      chk("nouse_fwd_d", fwd_d_rt, 0);
      tick(); idle();
      repeat (3) tick();

      // div then mfhi, then mult then mfhi
      for (int j = 0; j < 2; j++) begin
         int lat;
         lat = (j == 0) ? DIV : MUL;
         tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, (j == 0));
         tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 10, 0, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < lat; i++) begin
            settle();
            chk("md_wait_stall", stall, 1);
            chk("md_wait_busy",  md_busy, 1);
            tick();
         end
         settle();
         chk("md_issue_stall", stall, 0);
         chk("md_issue_busy",  md_busy, 0);
         tick(); idle();
      end

      // flush: div running, lw $3 in E is flushed, reader of $3 sees nothing
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
      tick(); drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 3, 2, 1'b0, 1'b0, 1'b0);
      tick(); idle(); flush = 1'b1;
      tick(); flush = 1'b0;
      drive(1'b1, 3, 1'b1, 0, 0, 1'b0, 0, 4, 0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("fl_stall", stall, 0);
      chk("fl_fwd_d", fwd_d_rs, 0);
      chk("fl_busy",  md_busy, 1);
      for (int i = 0; i < 7; i++) begin
         tick(); idle(); settle();
         chk("fl_div_busy", md_busy, 1);
      end
      tick(); settle();
      chk("fl_div_done", md_busy, 0);

      // mixed sequence checked by the model
      tick();
      send(1, 1'b1, 1, 2, 1'b1, 0, 4, 1, 1'b0, 1'b0, 1'b0);
      send(4, 1'b1, 0, 4, 1'b1, 2, 5, 3, 1'b0, 1'b0, 1'b0);
      send(5, 1'b1, 1, 0, 1'b0, 0, 6, 2, 1'b0, 1'b0, 1'b0);
      send(6, 1'b1, 3, 5, 1'b1, 3, 7, 0, 1'b0, 1'b0, 1'b0);
      send(7, 1'b1, 0, 6, 1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      send(0, 1'b0, 0, 0, 1'b0, 0, 13, 0, 1'b1, 1'b0, 1'b0);
      send(13, 1'b1, 0, 13, 1'b1, 0, 14, 1, 1'b0, 1'b0, 1'b0);
      send(14, 1'b1, 0, 13, 1'b1, 1, 15, 2, 1'b0, 1'b0, 1'b0);
      idle();
      repeat (4) tick();

      // reset in the middle of a multiply clears the counter
      drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
      tick(); idle();
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      settle();
      chk("rst_mid_md", md_busy, 0);

      // STAGES=5 instance: writer tnew 4, reader tuse 0
      tick(); p_drive(1'b1, 0, 1'b0, 0, 7, 4);
      tick(); p_drive(1'b1, 7, 1'b1, 0, 8, 0);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("p5_stall", p_stall, 1);
         tick();
      end
      settle();
      chk("p5_release", p_stall, 0);
      chk("p5_fwd_d",   p_fwd_d_rs, 5);
      tick(); p_drive(1'b0, 0, 1'b0, 0, 0, 0);
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
